// File: rtl/max_pool_reduce.sv
// Reduces each 2x2 window of samples, tagged by a one-hot position selector, to its signed maximum.
// Writes one pooled value per window to base+window_index and flags completion and protocol errors.
module max_pool_reduce #(
    parameter int matrix_size = 24,
    parameter int add_size    = 20,
    parameter int data_width  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic        [add_size-1:0]   out_add_base,
    input  logic        [3:0]            sel,
    input  logic signed [data_width-1:0] data_in,
    output logic signed [data_width-1:0] max_out,
    output logic        [add_size-1:0]   out_add,
    output logic                         out_valid,
    output logic                         done,
    output logic                         err
);

    localparam logic [add_size-1:0] NUM_WINDOWS = add_size'((matrix_size - 1) * (matrix_size - 1));

    typedef enum logic [1:0] {WAIT_P0, P1, P2, P3} state_t;

    state_t                        state;
    state_t                        next_state;
    logic        [add_size-1:0]    base;
    logic        [add_size-1:0]    win_cnt;
    logic        [add_size-1:0]    win_next;
    logic signed [data_width-1:0]  run_max;
    logic signed [data_width-1:0]  cand_max;
    logic        [3:0]             expected_sel;
    logic                          start;
    logic                          advance;
    logic                          emit;
    logic                          proto_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_P0;
        end else begin
            state <= next_state;
        end
    end

    // A 0001 selector always opens a fresh window, even from the middle of another one.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = P1;
        end else if (advance) begin
            case (state)
                P1:      next_state = P2;
                P2:      next_state = P3;
                default: next_state = WAIT_P0;
            endcase
        end else if (emit || proto_err) begin
            next_state = WAIT_P0;
        end
    end

    always_comb begin
        expected_sel = 4'b0001 << state;
        start        = 1'b0;
        advance      = 1'b0;
        emit         = 1'b0;
        proto_err    = 1'b0;
        if (!done && sel != 4'b0000) begin
            if (sel == 4'b0001) begin
                start     = 1'b1;
                proto_err = (state != WAIT_P0);
            end else if (sel == expected_sel) begin
                if (state == P3) begin
                    emit = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end else begin
                proto_err = 1'b1;
            end
        end
    end

    assign cand_max = (data_in > run_max) ? data_in : run_max;
    assign win_next = win_cnt + add_size'(1);

    // Address and max are only updated on a write strobe so the write port sees stable values otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            base      <= out_add_base;
            run_max   <= '0;
            max_out   <= '0;
            out_add   <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            win_cnt   <= '0;
        end else begin
            out_valid <= emit;
            if (start) begin
                run_max <= data_in;
            end else if (advance) begin
                run_max <= cand_max;
            end
            if (emit) begin
                max_out <= cand_max;
                out_add <= base + win_cnt;
                win_cnt <= win_next;
                if (win_next == NUM_WINDOWS) begin
                    done <= 1'b1;
                end
            end
            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_max_pool_reduce.sv
// Self-checking bench for max_pool_reduce on a 3x3 map (4 windows): fixed vectors, corner sequences,
// and randomized traffic compared against a queue-based window model.
module tb_max_pool_reduce;

    localparam int MS = 3;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int WINDOWS = (MS - 1) * (MS - 1);

    typedef struct {
        logic        [3:0]    sel;
        logic signed [DW-1:0] data;
        logic                 exp_valid;
        logic signed [DW-1:0] exp_max;
        logic        [AW-1:0] exp_add;
        logic                 exp_done;
        logic                 exp_err;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic        [AW-1:0] out_add_base = '0;
    logic        [3:0]    sel = '0;
    logic signed [DW-1:0] data_in = '0;
    logic signed [DW-1:0] max_out;
    logic        [AW-1:0] out_add;
    logic                 out_valid;
    logic                 done;
    logic                 err;

    int n_compared = 0;
    int n_mismatched = 0;
    int strobes = 0;

    // Reference model state: the samples accepted so far in the current window.
    logic signed [DW-1:0] q[$];
    logic        [AW-1:0] m_base, m_cnt, m_add;
    logic signed [DW-1:0] m_max;
    logic                 m_valid, m_done, m_err;

    max_pool_reduce #(.matrix_size(MS), .add_size(AW), .data_width(DW)) dut (
        .clk(clk),
        .reset(reset),
        .out_add_base(out_add_base),
        .sel(sel),
        .data_in(data_in),
        .max_out(max_out),
        .out_add(out_add),
        .out_valid(out_valid),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] actual, input logic signed [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic signed [DW-1:0] em,
                               input logic [AW-1:0] ea, input logic ed, input logic ee);
        check({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        check({name, ".max_out"}, 32'(max_out), 32'(em));
        check({name, ".out_add"}, {12'd0, out_add}, {12'd0, ea});
        check({name, ".done"}, {31'd0, done}, {31'd0, ed});
        check({name, ".err"}, {31'd0, err}, {31'd0, ee});
    endtask

    task automatic modelReset(input logic [AW-1:0] b);
        q.delete();
        m_base = b; m_cnt = '0; m_add = '0; m_max = '0;
        m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic modelStep(input logic [3:0] s, input logic signed [DW-1:0] d);
        logic signed [DW-1:0] mx;
        logic [3:0] want;
        m_valid = 1'b0;
        if (m_done || s == 4'b0000) return;
        want = 4'b0001 << q.size();
        if (s == 4'b0001) begin
            if (q.size() != 0) m_err = 1'b1;
            q.delete();
            q.push_back(d);
        end else if (q.size() > 0 && s == want) begin
            q.push_back(d);
            if (q.size() == 4) begin
                mx = q[0];
                foreach (q[k]) if (q[k] > mx) mx = q[k];
                m_max = mx;
                m_add = m_base + m_cnt;
                m_cnt = m_cnt + 1'b1;
                m_valid = 1'b1;
                if (m_cnt == AW'(WINDOWS)) m_done = 1'b1;
                q.delete();
            end
        end else begin
            m_err = 1'b1;
            q.delete();
        end
    endtask

    task automatic doReset(input logic [AW-1:0] b);
        @(negedge clk);
        reset = 1'b1;
        out_add_base = b;
        sel = 4'b0000;
        @(posedge clk);
        #1;
        modelReset(b);
        strobes = 0;
        checkOutput("reset", m_valid, m_max, m_add, m_done, m_err);
    endtask

    task automatic applyStimulus(input string name, input logic [3:0] s, input logic signed [DW-1:0] d);
        @(negedge clk);
        reset = 1'b0;
        sel = s;
        data_in = d;
        @(posedge clk);
        #1;
        modelStep(s, d);
        if (out_valid === 1'b1) strobes++;
        checkOutput(name, m_valid, m_max, m_add, m_done, m_err);
    endtask

    initial begin
        vec_t vecs[16];
        logic signed [DW-1:0] win_data[4][4];
        logic signed [DW-1:0] win_max[4];
        logic [3:0] rs;
        logic [3:0] want;
        int r;

        win_data = '{'{16'sd5, -16'sd2, 16'sd7, 16'sd1},
                     '{16'sd0, 16'sd0, 16'sd0, 16'sd0},
                     '{-16'sd8, -16'sd3, -16'sd9, -16'sd4},
                     '{16'sd32767, -16'sd32768, 16'sd0, 16'sd1}};
        win_max = '{16'sd7, 16'sd0, -16'sd3, 16'sd32767};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                vecs[i*4+j].sel       = 4'b0001 << j;
                vecs[i*4+j].data      = win_data[i][j];
                vecs[i*4+j].exp_valid = (j == 3);
                vecs[i*4+j].exp_max   = (j == 3) ? win_max[i] : ((i == 0) ? 16'sd0 : win_max[i-1]);
                vecs[i*4+j].exp_add   = (j == 3) ? AW'(32'h100 + i) : ((i == 0) ? '0 : AW'(32'h100 + i - 1));
                vecs[i*4+j].exp_done  = (i == 3 && j == 3);
                vecs[i*4+j].exp_err   = 1'b0;
            end
        end

        // Four full windows ending in done, then ignored traffic once done.
        doReset(20'h100);
        for (int v = 0; v < 16; v++) begin
            applyStimulus("t1_model", vecs[v].sel, vecs[v].data);
            checkOutput("t1_table", vecs[v].exp_valid, vecs[v].exp_max, vecs[v].exp_add,
                        vecs[v].exp_done, vecs[v].exp_err);
        end
        for (int v = 0; v < 8; v++) applyStimulus("t6_model", 4'b0001 << (v % 4), DW'(100 + v));
        checkOutput("t6_after_done", 1'b0, 16'sd32767, 20'h103, 1'b1, 1'b0);
        check("t6_strobes", strobes, 4);

        // Restart in the middle of a window.
        doReset(20'h100);
        applyStimulus("t2", 4'b0001, 16'sd3);
        applyStimulus("t2", 4'b0010, 16'sd9);
        applyStimulus("t2", 4'b0001, 16'sd4);
        applyStimulus("t2", 4'b0010, 16'sd2);
        applyStimulus("t2", 4'b0100, 16'sd6);
        applyStimulus("t2", 4'b1000, 16'sd1);
        checkOutput("t2_end", 1'b1, 16'sd6, 20'h100, 1'b0, 1'b1);
        check("t2_strobes", strobes, 1);

        // Bubbles inside a window.
        doReset(20'h100);
        applyStimulus("t3", 4'b0001, 16'sd1);
        applyStimulus("t3", 4'b0000, DW'($urandom));
        applyStimulus("t3", 4'b0000, DW'($urandom));
        applyStimulus("t3", 4'b0010, 16'sd2);
        applyStimulus("t3", 4'b0000, DW'($urandom));
        applyStimulus("t3", 4'b0100, 16'sd3);
        applyStimulus("t3", 4'b1000, 16'sd4);
        checkOutput("t3_end", 1'b1, 16'sd4, 20'h100, 1'b0, 1'b0);
        check("t3_strobes", strobes, 1);

        // Multi-hot selector aborts the window; the next clean window is still pooled.
        doReset(20'h100);
        applyStimulus("t4", 4'b0001, 16'sd10);
        applyStimulus("t4", 4'b0011, 16'sd50);
        checkOutput("t4_err", 1'b0, 16'sd0, 20'h0, 1'b0, 1'b1);
        applyStimulus("t4", 4'b0001, -16'sd1);
        applyStimulus("t4", 4'b0010, -16'sd5);
        applyStimulus("t4", 4'b0100, -16'sd7);
        applyStimulus("t4", 4'b1000, -16'sd2);
        checkOutput("t4_end", 1'b1, -16'sd1, 20'h100, 1'b0, 1'b1);

        // Reset mid-window with a new base.
        doReset(20'h100);
        applyStimulus("t5", 4'b0001, 16'sd100);
        applyStimulus("t5", 4'b0010, 16'sd200);
        doReset(20'h200);
        checkOutput("t5_reset", 1'b0, 16'sd0, 20'h0, 1'b0, 1'b0);
        applyStimulus("t5", 4'b0001, 16'sd1);
        applyStimulus("t5", 4'b0010, 16'sd2);
        applyStimulus("t5", 4'b0100, 16'sd3);
        applyStimulus("t5", 4'b1000, -16'sd4);
        checkOutput("t5_end", 1'b1, 16'sd3, 20'h200, 1'b0, 1'b0);

        // Randomized traffic, including a base that wraps the address space.
        for (int round = 0; round < 8; round++) begin
            doReset((round == 3) ? 20'hFFFFE : AW'($urandom));
            for (int c = 0; c < 60; c++) begin
                want = 4'b0001 << q.size();
                r = $urandom_range(0, 9);
                if (r <= 5) rs = want;
                else if (r <= 7) rs = 4'b0000;
                else if (r == 8) rs = 4'b0001;
                else rs = 4'($urandom);
                applyStimulus("rand", rs, DW'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
